// File: rtl/motor_command_arbiter.sv
// Motor command arbiter: picks host, RC or failsafe command source each cycle,
// mixes RC throttle/steer, and slew-limits the two PWM width outputs.
module motor_command_arbiter #(
   parameter int unsigned NEUTRAL      = 127,
   parameter int unsigned HOST_TIMEOUT = 51000,
   parameter int unsigned RAMP_DIV     = 255,
   parameter int unsigned RAMP_STEP    = 4,
   parameter int unsigned MODE_THRESH  = 192
) (
   input  logic       clk_255kHz,
   input  logic       reset,
   input  logic [7:0] host_left,
   input  logic [7:0] host_right,
   input  logic       host_strobe,
   input  logic [2:0] rc_valid,
   input  logic [7:0] rc_throttle,
   input  logic [7:0] rc_steer,
   input  logic [7:0] rc_mode,
   output logic [7:0] width_left,
   output logic [7:0] width_right,
   output logic [1:0] mode,
   output logic       at_target
);

   localparam int unsigned TW = $clog2(HOST_TIMEOUT + 1);
   localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   localparam logic [TW-1:0] TIMEOUT_C   = TW'(HOST_TIMEOUT);
   localparam logic [PW-1:0] PRESC_MAX_C = PW'(RAMP_DIV - 1);
   localparam logic [7:0]    NEUTRAL_C   = 8'(NEUTRAL);
   localparam logic [7:0]    THRESH_C    = 8'(MODE_THRESH);
   localparam logic [8:0]    STEP_C      = 9'(RAMP_STEP);

   typedef enum logic [1:0] {
      ST_FAILSAFE = 2'b00,
      ST_HOST     = 2'b01,
      ST_RC       = 2'b10
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_host_left;
   logic [7:0]    r_host_right;
   logic [7:0]    r_width_left;
   logic [7:0]    r_width_right;

   logic              w_rc_override;
   logic              w_tick;
   logic signed [9:0] w_thr;
   logic signed [9:0] w_steer_off;
   logic signed [9:0] w_mix_left;
   logic signed [9:0] w_mix_right;
   logic [7:0]        w_target_left;
   logic [7:0]        w_target_right;

   function automatic logic [7:0] f_clamp(input logic signed [9:0] v);
      if (v < 10'sd0)
         return 8'd0;
      else if (v > 10'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

   // Move cur toward tgt by at most STEP_C; lands exactly on tgt when close enough.
   function automatic logic [7:0] f_ramp(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] diff;
      logic [8:0] nxt;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         nxt  = (diff <= STEP_C) ? {1'b0, tgt} : ({1'b0, cur} + STEP_C);
      end else begin
         diff = {1'b0, cur} - {1'b0, tgt};
         nxt  = (diff <= STEP_C) ? {1'b0, tgt} : ({1'b0, cur} - STEP_C);
      end
      return nxt[7:0];
   endfunction

   assign w_rc_override = (rc_valid == 3'b111) && (rc_mode >= THRESH_C);
   assign w_tick        = (r_presc == PRESC_MAX_C);

   // Host watchdog: restarts on each strobe, saturates at the timeout value.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset)
         r_timer <= TIMEOUT_C;
      else if (host_strobe)
         r_timer <= '0;
      else if (r_timer < TIMEOUT_C)
         r_timer <= r_timer + 1'b1;
   end

   // Latch host widths on every strobe, regardless of the current source.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset) begin
         r_host_left  <= NEUTRAL_C;
         r_host_right <= NEUTRAL_C;
      end else if (host_strobe) begin
         r_host_left  <= host_left;
         r_host_right <= host_right;
      end
   end

   // Source selection: RC override beats a fresh host strobe, which beats a live host session.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset)
         r_state <= ST_FAILSAFE;
      else if (w_rc_override)
         r_state <= ST_RC;
      else if (host_strobe)
         r_state <= ST_HOST;
      else if ((r_state == ST_HOST) && (r_timer < TIMEOUT_C))
         r_state <= ST_HOST;
      else
         r_state <= ST_FAILSAFE;
   end

   // Free-running ramp prescaler; mode changes do not realign it.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + 1'b1;
   end

   // Arcade mix of throttle and centred steer, evaluated in signed 10-bit.
   always_comb begin
      w_thr       = signed'({2'b00, rc_throttle});
      w_steer_off = signed'({2'b00, rc_steer}) - 10'sd128;
      w_mix_left  = w_thr + w_steer_off;
      w_mix_right = w_thr - w_steer_off;
   end

   // Per-source width targets, driven by the registered state.
   always_comb begin
      w_target_left  = NEUTRAL_C;
      w_target_right = NEUTRAL_C;
      case (r_state)
         ST_HOST: begin
            w_target_left  = r_host_left;
            w_target_right = r_host_right;
         end
         ST_RC: begin
            w_target_left  = f_clamp(w_mix_left);
            w_target_right = f_clamp(w_mix_right);
         end
         default: begin
            w_target_left  = NEUTRAL_C;
            w_target_right = NEUTRAL_C;
         end
      endcase
   end

   // Output widths: snap to neutral in failsafe, otherwise slew on ramp ticks only.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset) begin
         r_width_left  <= NEUTRAL_C;
         r_width_right <= NEUTRAL_C;
      end else if (r_state == ST_FAILSAFE) begin
         r_width_left  <= NEUTRAL_C;
         r_width_right <= NEUTRAL_C;
      end else if (w_tick) begin
         r_width_left  <= f_ramp(r_width_left, w_target_left);
         r_width_right <= f_ramp(r_width_right, w_target_right);
      end
   end

   assign width_left  = r_width_left;
   assign width_right = r_width_right;
   assign mode        = r_state;
   assign at_target   = (r_width_left == w_target_left) && (r_width_right == w_target_right);

endmodule

// File: tb/tb_motor_command_arbiter.sv
// Directed self-checking bench for motor_command_arbiter (short timeout and ramp period).
module tb_motor_command_arbiter;

   logic       clk_255kHz = 1'b0;
   logic       reset;
   logic [7:0] host_left;
   logic [7:0] host_right;
   logic       host_strobe;
   logic [2:0] rc_valid;
   logic [7:0] rc_throttle;
   logic [7:0] rc_steer;
   logic [7:0] rc_mode;
   logic [7:0] width_left;
   logic [7:0] width_right;
   logic [1:0] mode;
   logic       at_target;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_255kHz = ~clk_255kHz;

   motor_command_arbiter #(
      .NEUTRAL      (127),
      .HOST_TIMEOUT (20),
      .RAMP_DIV     (4),
      .RAMP_STEP    (4),
      .MODE_THRESH  (192)
   ) dut (
      .clk_255kHz  (clk_255kHz),
      .reset       (reset),
      .host_left   (host_left),
      .host_right  (host_right),
      .host_strobe (host_strobe),
      .rc_valid    (rc_valid),
      .rc_throttle (rc_throttle),
      .rc_steer    (rc_steer),
      .rc_mode     (rc_mode),
      .width_left  (width_left),
      .width_right (width_right),
      .mode        (mode),
      .at_target   (at_target)
   );

   task automatic tick();
      @(posedge clk_255kHz);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      host_left   = 8'd0;
      host_right  = 8'd0;
      host_strobe = 1'b0;
      rc_valid    = 3'b000;
      rc_throttle = 8'd0;
      rc_steer    = 8'd128;
      rc_mode     = 8'd0;
      #12;
      reset = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (mode !== 2'b00) begin
         n_fail++; $display("FAIL reset_mode: got %b want 00", mode);
      end
      n_checks++;
      if (width_left !== 8'd127 || width_right !== 8'd127) begin
         n_fail++; $display("FAIL reset_widths: got %0d/%0d want 127/127", width_left, width_right);
      end
      n_checks++;
      if (at_target !== 1'b1) begin
         n_fail++; $display("FAIL reset_at_target: got %b want 1", at_target);
      end
   endtask

   task automatic test_host_ramp();
      int pl, pr, exp_l, exp_r, last_chg, nchg;
      host_left   = 8'd200;
      host_right  = 8'd100;
      host_strobe = 1'b1;
      tick();
      host_strobe = 1'b0;
      n_checks++;
      if (mode !== 2'b01) begin
         n_fail++; $display("FAIL host_enter: mode got %b want 01", mode);
      end
      pl = 127; pr = 127; last_chg = 0; nchg = 0;
      for (int c = 1; c <= 150 && !(width_left == 8'd200 && width_right == 8'd100); c++) begin
         host_strobe = ((c % 8) == 0);
         tick();
         host_strobe = 1'b0;
         if (int'(width_left) != pl) begin
            exp_l = ((200 - pl) > 4) ? pl + 4 : 200;
            exp_r = ((pr - 100) > 4) ? pr - 4 : 100;
            n_checks++;
            if (width_left !== 8'(exp_l)) begin
               n_fail++; $display("FAIL ramp_left_step: got %0d want %0d", width_left, exp_l);
            end
            n_checks++;
            if (width_right !== 8'(exp_r)) begin
               n_fail++; $display("FAIL ramp_right_step: got %0d want %0d", width_right, exp_r);
            end
            if (nchg > 0) begin
               n_checks++;
               if ((c - last_chg) != 4) begin
                  n_fail++; $display("FAIL ramp_tick_gap: got %0d want 4", c - last_chg);
               end
            end
            nchg++;
            last_chg = c;
         end else begin
            n_checks++;
            if (int'(width_right) != pr) begin
               n_fail++; $display("FAIL ramp_hold_right: got %0d want %0d", width_right, pr);
            end
         end
         pl = int'(width_left);
         pr = int'(width_right);
      end
      n_checks++;
      if (width_left !== 8'd200 || width_right !== 8'd100) begin
         n_fail++; $display("FAIL ramp_final: got %0d/%0d want 200/100", width_left, width_right);
      end
      n_checks++;
      if (nchg != 19) begin
         n_fail++; $display("FAIL ramp_tick_count: got %0d want 19", nchg);
      end
      n_checks++;
      if (at_target !== 1'b1 || mode !== 2'b01) begin
         n_fail++; $display("FAIL ramp_done: at_target %b mode %b want 1/01", at_target, mode);
      end
   endtask

   task automatic test_host_timeout();
      host_left   = 8'd150;
      host_right  = 8'd150;
      host_strobe = 1'b1;
      tick();
      host_strobe = 1'b0;
      n_checks++;
      if (mode !== 2'b01) begin
         n_fail++; $display("FAIL timeout_start: mode got %b want 01", mode);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_checks++;
         if (mode !== 2'b01) begin
            n_fail++; $display("FAIL timeout_hold: cycle %0d mode got %b want 01", k, mode);
         end
      end
      tick();
      n_checks++;
      if (mode !== 2'b00) begin
         n_fail++; $display("FAIL timeout_expire: mode got %b want 00", mode);
      end
      tick();
      n_checks++;
      if (width_left !== 8'd127 || width_right !== 8'd127 || at_target !== 1'b1) begin
         n_fail++; $display("FAIL timeout_snap: got %0d/%0d at_target %b want 127/127/1",
                            width_left, width_right, at_target);
      end
   endtask

   task automatic test_rc_mix();
      bit reached;
      bit mono;
      int prev;
      rc_valid    = 3'b111;
      rc_mode     = 8'd200;
      rc_throttle = 8'd250;
      rc_steer    = 8'd200;
      tick();
      n_checks++;
      if (mode !== 2'b10) begin
         n_fail++; $display("FAIL rc_enter: mode got %b want 10", mode);
      end
      reached = 1'b0;
      for (int c = 0; c < 300 && !reached; c++) begin
         tick();
         reached = at_target;
      end
      n_checks++;
      if (!reached) begin
         n_fail++; $display("FAIL rc_high_timeout: at_target got 0 want 1 within 300 cycles");
      end
      n_checks++;
      if (width_left !== 8'd255 || width_right !== 8'd178) begin
         n_fail++; $display("FAIL rc_high_mix: got %0d/%0d want 255/178", width_left, width_right);
      end
      rc_throttle = 8'd10;
      rc_steer    = 8'd0;
      reached = 1'b0;
      mono    = 1'b1;
      prev    = int'(width_left);
      for (int c = 0; c < 400 && !reached; c++) begin
         tick();
         if (int'(width_left) > prev) mono = 1'b0;
         prev    = int'(width_left);
         reached = at_target;
      end
      n_checks++;
      if (!reached) begin
         n_fail++; $display("FAIL rc_low_timeout: at_target got 0 want 1 within 400 cycles");
      end
      n_checks++;
      if (width_left !== 8'd0 || width_right !== 8'd138) begin
         n_fail++; $display("FAIL rc_low_mix: got %0d/%0d want 0/138", width_left, width_right);
      end
      n_checks++;
      if (!mono) begin
         n_fail++; $display("FAIL rc_low_wrap: left rose during descent got 1 want 0");
      end
   endtask

   task automatic test_rc_exit();
      rc_valid = 3'b011;
      tick();
      n_checks++;
      if (mode !== 2'b00) begin
         n_fail++; $display("FAIL rc_drop: mode got %b want 00", mode);
      end
      tick();
      n_checks++;
      if (width_left !== 8'd127 || width_right !== 8'd127) begin
         n_fail++; $display("FAIL rc_drop_snap: got %0d/%0d want 127/127", width_left, width_right);
      end
      host_left   = 8'd60;
      host_right  = 8'd70;
      host_strobe = 1'b1;
      tick();
      host_strobe = 1'b0;
      n_checks++;
      if (mode !== 2'b01) begin
         n_fail++; $display("FAIL rc_then_host: mode got %b want 01", mode);
      end
      host_left   = 8'd90;
      host_right  = 8'd80;
      host_strobe = 1'b1;
      rc_valid    = 3'b111;
      tick();
      host_strobe = 1'b0;
      n_checks++;
      if (mode !== 2'b10) begin
         n_fail++; $display("FAIL strobe_vs_rc: mode got %b want 10", mode);
      end
      rc_valid = 3'b000;
      tick();
      n_checks++;
      if (mode !== 2'b00) begin
         n_fail++; $display("FAIL no_stale_resume: mode got %b want 00", mode);
      end
   endtask

   task automatic test_reset_mid_ramp();
      bit moved;
      host_left   = 8'd250;
      host_right  = 8'd20;
      host_strobe = 1'b1;
      tick();
      host_strobe = 1'b0;
      moved = 1'b0;
      for (int c = 0; c < 20 && !moved; c++) begin
         tick();
         moved = (width_left != 8'd127);
      end
      n_checks++;
      if (!moved) begin
         n_fail++; $display("FAIL midramp_start: left got %0d want not 127", width_left);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (width_left !== 8'd127 || width_right !== 8'd127 || mode !== 2'b00) begin
         n_fail++; $display("FAIL async_reset: got %0d/%0d mode %b want 127/127/00",
                            width_left, width_right, mode);
      end
      tick();
      #2;
      reset = 1'b0;
      tick();
      n_checks++;
      if (mode !== 2'b00 || at_target !== 1'b1) begin
         n_fail++; $display("FAIL post_reset: mode %b at_target %b want 00/1", mode, at_target);
      end
   endtask

   initial begin
      test_reset();
      test_host_ramp();
      test_host_timeout();
      test_rc_mix();
      test_rc_exit();
      test_reset_mid_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_command_arbiter.md
Name: motor_command_arbiter

Overview:
- Sits between the command sources and the two PWMGenerator instances.
- Selects one command source per cycle: host registers (from the bus peripheral) or RC receiver channels (throttle/steer with arcade mixing). Falls back to failsafe neutral when neither source is valid.
- Slew-limits the selected targets before driving the generators' 8-bit width inputs.
- Runs entirely in the clk_255kHz domain.

Parameters:
- NEUTRAL, 127: width driven in failsafe; reset value of outputs and latched host values.
- HOST_TIMEOUT, 51000: clk_255kHz cycles (200 ms) without host_strobe before HOST mode expires.
- RAMP_DIV, 255: ramp prescaler period in cycles (1 ms per ramp tick).
- RAMP_STEP, 4: maximum width change per ramp tick.
- MODE_THRESH, 192: rc_mode at or above this value requests RC override.

Ports:
- clk_255kHz  in  1  sole clock.
- reset  in  1  asynchronous, active-high; all registers take reset values immediately.
- host_left  in  8  host left width; sampled only on host_strobe.
- host_right  in  8  host right width; sampled only on host_strobe.
- host_strobe  in  1  one-cycle pulse, already synchronous to clk_255kHz; marks a fresh host command.
- rc_valid  in  3  [0] throttle, [1] steer, [2] mode-switch channel valid.
- rc_throttle  in  8  RC throttle period, 0..255.
- rc_steer  in  8  RC steer period, 0..255, centre 128.
- rc_mode  in  8  RC mode-switch channel period.
- width_left  out  8  to left PWMGenerator width.
- width_right  out  8  to right PWMGenerator width.
- mode  out  2  00 FAILSAFE, 01 HOST, 10 RC; 11 never driven.
- at_target  out  1  high when both widths equal their current targets.

Behaviour:
- Reset values:
  - width_left = width_right = NEUTRAL.
  - mode = FAILSAFE.
  - Latched host_left and host_right = NEUTRAL.
  - Host timer = HOST_TIMEOUT (expired).
  - Ramp prescaler = 0.
  - at_target = 1.
- rc_override = (rc_valid == 3'b111) && (rc_mode >= MODE_THRESH); combinational from inputs.
- Host timer:
  - Cleared to 0 on host_strobe; otherwise increments, saturating at HOST_TIMEOUT.
  - host_strobe also latches host_left and host_right, in every state including RC.
- State register updates every cycle, in priority order:
  - If rc_override: next state = RC.
  - Else if host_strobe: next state = HOST.
  - Else if state == HOST and timer < HOST_TIMEOUT: stay HOST.
  - Otherwise: FAILSAFE.
- Consequences of that ordering:
  - RC dropping override never returns directly to HOST unless a strobe arrives in the same cycle or later. A stale host command is never resumed.
  - HOST expires on the cycle after the timer reaches HOST_TIMEOUT, i.e. HOST_TIMEOUT+1 cycles after the last strobe.
- Targets (combinational from the registered state):
  - FAILSAFE: both targets = NEUTRAL.
  - HOST: targets = latched host values.
  - RC: s = rc_steer − 128 (signed 9-bit); left = throttle + s, right = throttle − s, computed in signed 10-bit; each clamped to 0..255.
- Ramp:
  - Prescaler counts 0..RAMP_DIV−1 and wraps; a tick occurs when it equals RAMP_DIV−1.
  - The prescaler free-runs and is not reset by mode changes.
  - On a tick, per output: if |target − width| ≤ RAMP_STEP, width = target; else width moves RAMP_STEP toward target. No overshoot, no wrap-around at 0 or 255.
  - Between ticks, widths hold.
- Failsafe snap: on any cycle where the registered state is FAILSAFE, widths load NEUTRAL directly, with no ramp. Outputs therefore reach NEUTRAL one cycle after entering FAILSAFE.
- Latency: an input change affects state at the next edge; targets follow state combinationally; widths change at the first ramp tick after that (or the following edge in FAILSAFE).
- at_target = (width_left == target_left) && (width_right == target_right); combinational from registers and targets.
- Reset mid-operation: asynchronous return to all reset values; first valid state evaluation occurs at the first clock edge after reset deasserts.

Test Plan:
- Reset, then 10 cycles idle -> mode=00, widths=127/127, at_target=1.
- RAMP_DIV=4, RAMP_STEP=4; host_strobe with 200/100 -> mode=01 next cycle; left rises 127→131→135… every 4 cycles and reaches 200 exactly on the last tick (a final step of 1); right falls to 100 likewise; at_target=1 afterwards.
- HOST_TIMEOUT=20; single strobe, no further strobes -> mode=01 for 20 cycles, then 00; widths equal 127 one cycle after entering FAILSAFE.
- RC: rc_valid=111, rc_mode=200, throttle=250, steer=200 -> mode=10, targets left=255 (322 clamped), right=178; throttle=10, steer=0 -> left=0 (−118 clamped), right=138.
- In RC, clear rc_valid[2] -> FAILSAFE; a later host_strobe -> HOST. A host_strobe in the same cycle rc_override asserts -> RC, with host values still latched.
- Assert reset mid-ramp, asynchronously between edges -> widths=127 and mode=00 before the next clock edge.
